l1_sram_arbiter: RTL

L1_SRAM_ARBITER -- requirements
Module: l1_sram_arbiter

---
 rtl/l1_sram_arbiter_if.sv | 31 +++
 rtl/l1_sram_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/l1_sram_arbiter_if.sv
// Requester-side bus of the L1 SRAM arbiter.
//   req_valid/req_ready : per-requester handshake (transfer when both high)
//   req_wea/addr/wdata  : packed per-requester payloads (wea all-zero = read)
//   rsp_valid           : per-requester response pulse
//   rsp_rdata           : shared response data, qualified by rsp_valid
// Modports: master = requester side, slave = arbiter side.
interface l1_sram_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 32
);
  localparam int unsigned BW = DW / 8;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*BW-1:0] req_wea;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_wea, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wea, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/l1_sram_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto a
// dual-port SRAM (winner A -> port 0, winner B -> port 1).
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : requester handshake, payloads and responses
//   sram_cen        : active-low chip enable (low when anything is granted)
//   sram_*0/sram_*1 : port 0 / port 1 controls; sram_rdata* return read data
// Optional feature macro ARB_STATS_EN adds stat_grants / stat_conflicts
// (16-bit saturating counters).
module l1_sram_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 32
) (
  input  logic                clk,
  input  logic                rst,
  l1_sram_arbiter_if.slave    bus,
  output logic                sram_cen,
  output logic [DW/8-1:0]     sram_wea0,
  output logic [AW-1:0]       sram_addr0,
  output logic [DW-1:0]       sram_wdata0,
  output logic [DW/8-1:0]     sram_wea1,
  output logic [AW-1:0]       sram_addr1,
  output logic [DW-1:0]       sram_wdata1,
  input  logic [DW-1:0]       sram_rdata0,
  input  logic [DW-1:0]       sram_rdata1
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]         stat_grants,
  output logic [15:0]         stat_conflicts
`endif
);
  localparam int unsigned BW = DW / 8;
  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] ptr, cand, a_idx, b_idx, last_idx, ptr_nxt;
  logic          a_found, b_found, a_grant, b_grant, same_conflict;
  logic [BW-1:0] wea_a, wea_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic [NREQ-1:0] ready_c;

  logic            p1_pend;
  logic [IW-1:0]   p1_idx;
  logic [DW-1:0]   p1_data;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;

  // Circular scan from ptr: first valid is A, next valid is B.
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    cand    = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = IW'((int'(ptr) + k) % int'(NREQ));
      if (bus.req_valid[cand]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = cand;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = cand;
        end
      end
    end
  end

  assign wea_a   = bus.req_wea[int'(a_idx)*int'(BW) +: BW];
  assign wea_b   = bus.req_wea[int'(b_idx)*int'(BW) +: BW];
  assign addr_a  = bus.req_addr[int'(a_idx)*int'(AW) +: AW];
  assign addr_b  = bus.req_addr[int'(b_idx)*int'(AW) +: AW];
  assign wdata_a = bus.req_wdata[int'(a_idx)*int'(DW) +: DW];
  assign wdata_b = bus.req_wdata[int'(b_idx)*int'(DW) +: DW];

  // Same-address pair is only safe when both are reads.
  assign same_conflict = b_found && (addr_b == addr_a) && ((|wea_a) || (|wea_b));
  assign a_grant = a_found && !rst;
  // Port 1 stays idle while its previous response is still held.
  assign b_grant = b_found && !same_conflict && !p1_pend && !rst;

  // Grants and SRAM port drive; an idle port 1 mirrors port 0 with no write.
  always_comb begin
    ready_c     = '0;
    sram_cen    = 1'b1;
    sram_wea0   = '0;
    sram_addr0  = addr_a;
    sram_wdata0 = wdata_a;
    sram_wea1   = '0;
    sram_addr1  = addr_a;
    sram_wdata1 = wdata_a;
    if (a_grant) begin
      ready_c[a_idx] = 1'b1;
      sram_cen       = 1'b0;
      sram_wea0      = wea_a;
    end
    if (b_grant) begin
      ready_c[b_idx] = 1'b1;
      sram_wea1      = wea_b;
      sram_addr1     = addr_b;
      sram_wdata1    = wdata_b;
    end
  end

  assign bus.req_ready = ready_c;

  // Pointer advances past the last granted winner.
  assign last_idx = b_grant ? b_idx : a_idx;
  assign ptr_nxt  = (int'(last_idx) == int'(NREQ) - 1) ? '0 : last_idx + IW'(1);

  // Next response: held port-1 response first, port 0 overrides the data.
  always_comb begin
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    if (p1_pend) begin
      rsp_valid_d[p1_idx] = 1'b1;
      rsp_rdata_d         = p1_data;
    end
    if (a_grant) begin
      rsp_valid_d[a_idx] = 1'b1;
      rsp_rdata_d        = (|wea_a) ? '0 : sram_rdata0;
    end
  end

  // Pointer, response and held port-1 state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      p1_pend     <= 1'b0;
      p1_idx      <= '0;
      p1_data     <= '0;
    end else begin
      if (a_grant) ptr <= ptr_nxt;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      p1_pend     <= b_grant;
      if (b_grant) begin
        p1_idx  <= b_idx;
        p1_data <= (|wea_b) ? '0 : sram_rdata1;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

`ifdef ARB_STATS_EN
  logic        conflict_c;
  logic [1:0]  n_grant_c;
  logic [16:0] grant_sum, conf_sum;

  // A valid B that was held back by address conflict or a pending port-1 response.
  assign conflict_c = b_found && !rst && (same_conflict || p1_pend);
  assign n_grant_c  = {1'b0, a_grant} + {1'b0, b_grant};
  assign grant_sum  = {1'b0, stat_grants} + 17'(n_grant_c);
  assign conf_sum   = {1'b0, stat_conflicts} + 17'(conflict_c);

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else begin
      stat_grants    <= grant_sum[16] ? 16'hFFFF : grant_sum[15:0];
      stat_conflicts <= conf_sum[16]  ? 16'hFFFF : conf_sum[15:0];
    end
  end
`endif
endmodule
